regfile_wport_arbiter: RTL and testbench

REGFILE_WPORT_ARBITER -- requirements
Module: regfile_wport_arbiter

---
 rtl/regfile_wport_arbiter_pkg.sv | 22 ++
 rtl/regfile_clear_seq.sv | 36 +++
 rtl/regfile_wport_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_wport_arbiter_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 15;

    // r15 has no storage behind it, so writes to it are dropped at the port.
    localparam logic [REG_ADDR_W-1:0] NO_REG_ADDR = 4'd15;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FORCE = 2'd2
    } state_e;

    // True when a destination maps onto a real register.
    function automatic logic is_writable(input logic [REG_ADDR_W-1:0] dest);
        return dest != NO_REG_ADDR;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Index counter that walks r0..r(NUM_REGS-1) while the arbiter is clearing
// the register file; done marks the cycle that writes the last register.
module regfile_clear_seq
    import regfile_wport_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    output logic [REG_ADDR_W-1:0] idx,
    output logic                  done
);

    logic [REG_ADDR_W-1:0] idx_q;
    logic [REG_ADDR_W-1:0] idx_d;

    // Advance one register per active cycle, wrapping to 0 after the last one.
    always_comb begin
        done  = active && (idx_q == REG_ADDR_W'(NUM_REGS - 1));
        idx_d = idx_q;
        if (active) begin
            idx_d = done ? '0 : idx_q + 1'b1;
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single write-port arbiter between the pipeline WB stage and an auxiliary
// multi-cycle unit. The pipeline wins by default; an aux request that has
// waited STARVE_LIMIT cycles forces a one-cycle pipeline stall to drain it.
// Optional feature macro: REGFILE_CLEAR_EN -- after reset, write 0 to
// r0..r14 (one per cycle) before normal arbitration starts.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en_in,
    input  logic [REG_ADDR_W-1:0] wb_dest_in,
    input  logic [DATA_W-1:0]     wb_result_in,
    input  logic                  aux_valid,
    input  logic [REG_ADDR_W-1:0] aux_dest,
    input  logic [DATA_W-1:0]     aux_data,
    output logic                  aux_ready,
    output logic                  stall,
    output logic                  init_busy,
    output logic                  rf_wb_en,
    output logic [REG_ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0]     rf_result
);

    state_e                state_q;
    state_e                state_d;
    logic [3:0]            wait_q;
    logic [3:0]            wait_d;

`ifdef REGFILE_CLEAR_EN
    localparam state_e RESET_STATE = INIT;

    logic [REG_ADDR_W-1:0] init_idx;
    logic                  init_done;

    regfile_clear_seq u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .active (state_q == INIT && !rst),
        .idx    (init_idx),
        .done   (init_done)
    );
`else
    localparam state_e RESET_STATE = RUN;
`endif

    // Port arbitration: outputs depend on the current state and live requests.
    always_comb begin
        aux_ready = 1'b0;
        stall     = 1'b0;
        init_busy = 1'b0;
        rf_wb_en  = 1'b0;
        rf_dest   = '0;
        rf_result = '0;
        if (rst) begin
            stall = 1'b1;
        end else begin
            case (state_q)
`ifdef REGFILE_CLEAR_EN
                INIT: begin
                    init_busy = 1'b1;
                    stall     = 1'b1;
                    rf_wb_en  = 1'b1;
                    rf_dest   = init_idx;
                end
`endif
                RUN: begin
                    if (wb_en_in) begin
                        rf_wb_en  = is_writable(wb_dest_in);
                        rf_dest   = wb_dest_in;
                        rf_result = wb_result_in;
                    end else if (aux_valid) begin
                        aux_ready = 1'b1;
                        rf_wb_en  = is_writable(aux_dest);
                        rf_dest   = aux_dest;
                        rf_result = aux_data;
                    end
                end
                FORCE: begin
                    // Pipeline is frozen; its write is re-presented next cycle.
                    stall = 1'b1;
                    if (aux_valid) begin
                        aux_ready = 1'b1;
                        rf_wb_en  = is_writable(aux_dest);
                        rf_dest   = aux_dest;
                        rf_result = aux_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Starvation counter and next-state selection. FORCE is entered on the
    // cycle the count reaches the limit so the stall lands on the next cycle.
    always_comb begin
        if (!aux_valid || aux_ready) begin
            wait_d = '0;
        end else if (state_q == INIT) begin
            wait_d = wait_q;
        end else begin
            wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
        end

        state_d = state_q;
        case (state_q)
`ifdef REGFILE_CLEAR_EN
            INIT:    if (init_done) state_d = RUN;
`endif
            RUN:     if (wait_d == 4'(STARVE_LIMIT)) state_d = FORCE;
            FORCE:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter (STARVE_LIMIT=3). Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in;
    logic [3:0]  wb_dest_in;
    logic [31:0] wb_result_in;
    logic        aux_valid;
    logic [3:0]  aux_dest;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        stall;
    logic        init_busy;
    logic        rf_wb_en;
    logic [3:0]  rf_dest;
    logic [31:0] rf_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wport_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .wb_dest_in   (wb_dest_in),
        .wb_result_in (wb_result_in),
        .aux_valid    (aux_valid),
        .aux_dest     (aux_dest),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .stall        (stall),
        .init_busy    (init_busy),
        .rf_wb_en     (rf_wb_en),
        .rf_dest      (rf_dest),
        .rf_result    (rf_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic [3:0] wd, input logic [31:0] wr,
                         input logic av, input logic [3:0] ad, input logic [31:0] adat);
        wb_en_in     = wen;
        wb_dest_in   = wd;
        wb_result_in = wr;
        aux_valid    = av;
        aux_dest     = ad;
        aux_data     = adat;
    endtask

    // Sample all arbitration outputs and compare against expectations.
    task automatic expect_port(input string tag, input logic en, input logic [3:0] dest,
                               input logic [31:0] res, input logic ar, input logic st);
        @(negedge clk);
        check({tag, ".rf_wb_en"},  32'(rf_wb_en),  32'(en));
        check({tag, ".rf_dest"},   32'(rf_dest),   32'(dest));
        check({tag, ".rf_result"}, rf_result,      res);
        check({tag, ".aux_ready"}, 32'(aux_ready), 32'(ar));
        check({tag, ".stall"},     32'(stall),     32'(st));
        $display("txn %s: en=%0b dest=%0d data=0x%08h aux_ready=%0b stall=%0b init_busy=%0b",
                 tag, rf_wb_en, rf_dest, rf_result, aux_ready, stall, init_busy);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'd2, 32'h1111_1111, 1'b1, 4'd4, 32'h2222_2222);

        // Reset holds the port closed and the pipeline stalled.
        expect_port("reset", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        check("reset.init_busy", 32'(init_busy), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);

`ifdef REGFILE_CLEAR_EN
        for (int i = 0; i < 15; i++) begin
            expect_port($sformatf("init%0d", i), 1'b1, 4'(i), 32'h0, 1'b0, 1'b1);
            check("init.init_busy", 32'(init_busy), 32'd1);
            next_cycle();
        end
`endif

        // Idle in RUN.
        expect_port("idle", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        check("idle.init_busy", 32'(init_busy), 32'd0);
        next_cycle();

        // Pipeline wins a simultaneous request, aux follows a cycle later.
        drive(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, 4'd5, 32'h1234_5678);
        expect_port("both", 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 4'd3, 32'hDEAD_BEEF, 1'b1, 4'd5, 32'h1234_5678);
        expect_port("aux_only", 1'b1, 4'd5, 32'h1234_5678, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        next_cycle();

        // Starvation: three blocked cycles, then a forced aux slot, then back.
        drive(1'b1, 4'd7, 32'hAAAA_0007, 1'b1, 4'd9, 32'hBBBB_0009);
        for (int i = 1; i <= 3; i++) begin
            expect_port($sformatf("starve%0d", i), 1'b1, 4'd7, 32'hAAAA_0007, 1'b0, 1'b0);
            next_cycle();
        end
        expect_port("force", 1'b1, 4'd9, 32'hBBBB_0009, 1'b1, 1'b1);
        next_cycle();
        expect_port("after_force", 1'b1, 4'd7, 32'hAAAA_0007, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        next_cycle();

        // r15 writes are dropped but still service the requester.
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'hCAFE_F00D);
        expect_port("aux_r15", 1'b0, 4'd15, 32'hCAFE_F00D, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 4'd15, 32'h0BAD_0BAD, 1'b0, 4'd0, 32'h0);
        expect_port("wb_r15", 1'b0, 4'd15, 32'h0BAD_0BAD, 1'b0, 1'b0);
        next_cycle();

        // Aux withdraws its request while FORCE is pending.
        drive(1'b1, 4'd1, 32'h0000_0101, 1'b1, 4'd6, 32'h0000_0606);
        for (int i = 1; i <= 3; i++) begin
            expect_port($sformatf("wd_starve%0d", i), 1'b1, 4'd1, 32'h0000_0101, 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b1, 4'd1, 32'h0000_0101, 1'b0, 4'd6, 32'h0000_0606);
        expect_port("force_withdrawn", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        next_cycle();
        expect_port("after_withdraw", 1'b1, 4'd1, 32'h0000_0101, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        next_cycle();

        // Reset asserted during FORCE aborts it and restarts the counter.
        drive(1'b1, 4'd2, 32'h0000_0202, 1'b1, 4'd8, 32'h0000_0808);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
        end
        rst = 1'b1;
        expect_port("rst_in_force", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        next_cycle();
        rst = 1'b0;
`ifdef REGFILE_CLEAR_EN
        @(negedge clk);
        check("post_rst.init_busy", 32'(init_busy), 32'd1);
        repeat (15) next_cycle();
`endif
        for (int i = 1; i <= 3; i++) begin
            expect_port($sformatf("post_rst_starve%0d", i), 1'b1, 4'd2, 32'h0000_0202, 1'b0, 1'b0);
            next_cycle();
        end
        expect_port("post_rst_force", 1'b1, 4'd8, 32'h0000_0808, 1'b1, 1'b1);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
